// File: rtl/output_fifo_drain.sv
// output_fifo_drain: drains per-column output FIFOs row-major into a linear result memory
module output_fifo_drain #(
  parameter int DATA_SIZE  = 8,
  parameter int ARRAY_SIZE = 9,
  parameter int ROW_W      = 8,
  parameter int ADDR_W     = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ROW_W-1:0]                num_rows,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [ARRAY_SIZE-1:0]           fifo_empty,
  input  logic [DATA_SIZE*ARRAY_SIZE-1:0] fifo_data,
  output logic [ARRAY_SIZE-1:0]           fifo_r_en,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_SIZE-1:0]            mem_data,
  output logic                            busy,
  output logic                            done
);
  localparam int CW = $clog2(ARRAY_SIZE);
  localparam logic [CW-1:0] LAST_COL = CW'(ARRAY_SIZE - 1);
  typedef enum logic [1:0] {IDLE, REQ, CAP, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d, rows_q, rows_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_SIZE-1:0] mem_data_q, mem_data_d;
  logic mem_we_q, mem_we_d, done_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign done     = done_q;
  assign busy     = state_q != IDLE;
  // Next-state logic: pop one column per REQ, write it out in CAP, walk columns then rows
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    rows_d     = rows_q;
    addr_d     = addr_q;
    fifo_r_en  = '0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    unique case (state_q)
      IDLE: if (start) begin
        rows_d  = num_rows;
        addr_d  = base_addr;
        col_d   = '0;
        row_d   = '0;
        state_d = (num_rows == '0) ? DONE : REQ;
      end
      REQ: if (!fifo_empty[col_q]) begin
        fifo_r_en = {{(ARRAY_SIZE-1){1'b0}}, 1'b1} << col_q;
        state_d   = CAP;
      end
      CAP: begin
        mem_we_d   = 1'b1;
        mem_addr_d = addr_q;
        mem_data_d = fifo_data[col_q*DATA_SIZE +: DATA_SIZE];
        addr_d     = addr_q + ADDR_W'(1);
        col_d      = (col_q == LAST_COL) ? '0 : col_q + CW'(1);
        row_d      = (col_q == LAST_COL) ? row_q + ROW_W'(1) : row_q;
        state_d    = (col_q == LAST_COL && row_q == rows_q - ROW_W'(1)) ? DONE : REQ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and registered memory-side outputs; reset aborts any drain in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      rows_q     <= '0;
      addr_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rows_q     <= rows_d;
      addr_q     <= addr_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      done_q     <= state_q == DONE;
    end
  end
endmodule

// File: tb/tb_output_fifo_drain.sv
// tb_output_fifo_drain: randomized drains checked against a queue-based model of the FIFOs and memory
module tb_output_fifo_drain;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] num_rows = 0;
  logic [9:0] base_addr = 0;
  logic [8:0] fifo_empty = '1, fifo_r_en, mask = '0, en = '0;
  logic [71:0] fifo_data = '0;
  logic mem_we, busy, done;
  logic [9:0] mem_addr, last_addr = 0, exp_last = 0;
  logic [7:0] mem_data;
  logic [7:0] fq[9][$];
  logic [17:0] exp_q[$];
  int checks = 0, fails = 0, cyc = 0, start_cyc = 0, idx = 0, nwr = 0, nwr0 = 0;
  int done_cnt = 0, exp_n = 0, exp_lat = 0, wcyc = 0;
  bit rst_prev = 0, waiting = 0, chk_last = 0;

  output_fifo_drain dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .base_addr(base_addr),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_r_en(fifo_r_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: protocol checks every cycle, writes against the expected queue, done against latency/count
  always @(negedge clk) begin
    if (reset) begin
      idx = exp_q.size();
      rst_prev = 1;
      wcyc = 0;
    end else begin
      if (rst_prev) begin
        checks++;
        if ({fifo_r_en, mem_we, mem_addr, mem_data, busy, done} != '0) begin
          fails++;
          $display("FAIL reset_outputs: r_en=%h we=%b addr=%h data=%h busy=%b done=%b, want all 0", fifo_r_en, mem_we, mem_addr, mem_data, busy, done);
        end
      end
      rst_prev = 0;
      checks++;
      if ((fifo_r_en & (fifo_r_en - 9'd1)) != '0) begin
        fails++;
        $display("FAIL r_en_onehot: r_en=%b, want one-hot or zero", fifo_r_en);
      end
      checks++;
      if ((fifo_r_en & fifo_empty) != '0) begin
        fails++;
        $display("FAIL r_en_empty: r_en=%b empty=%b, want no overlap", fifo_r_en, fifo_empty);
      end
      if (mem_we) begin
        nwr++;
        last_addr = mem_addr;
        checks++;
        if (idx >= exp_q.size()) begin
          fails++;
          $display("FAIL unexpected_write: addr=%h data=%h, want no write", mem_addr, mem_data);
        end else if ({mem_addr, mem_data} != exp_q[idx]) begin
          fails++;
          $display("FAIL write_%0d: addr=%h data=%h, want addr=%h data=%h", idx, mem_addr, mem_data, exp_q[idx][17:8], exp_q[idx][7:0]);
        end
        idx++;
        checks++;
        if (!busy) begin
          fails++;
          $display("FAIL busy_on_write: busy=0, want 1");
        end
      end
      if (done) begin
        done_cnt++;
        checks += 4;
        if (busy) begin
          fails++;
          $display("FAIL busy_at_done: busy=1, want 0");
        end
        if (nwr - nwr0 != exp_n) begin
          fails++;
          $display("FAIL write_count: got %0d, want %0d", nwr - nwr0, exp_n);
        end
        if (cyc - start_cyc != exp_lat) begin
          fails++;
          $display("FAIL done_latency: got %0d, want %0d", cyc - start_cyc, exp_lat);
        end
        if (idx != exp_q.size()) begin
          fails++;
          $display("FAIL pending_writes: got %0d left, want 0", exp_q.size() - idx);
        end
        if (chk_last) begin
          checks++;
          if (last_addr != exp_last) begin
            fails++;
            $display("FAIL last_addr: got %h, want %h", last_addr, exp_last);
          end
        end
      end
      wcyc = waiting ? wcyc + 1 : 0;
      if (wcyc == 650) begin
        checks++;
        fails++;
        $display("FAIL timeout: no done after %0d cycles, want done", wcyc);
      end
    end
  end

  task automatic upd_empty();
    for (int c = 0; c < 9; c++) fifo_empty[c] = (fq[c].size() == 0) || mask[c];
  endtask

  // One clock: sample r_en before the edge, pop the model FIFOs just after it
  task automatic tick();
    @(negedge clk);
    en = fifo_r_en;
    @(posedge clk);
    #1;
    for (int c = 0; c < 9; c++)
      if (en[c] && fq[c].size() != 0) fifo_data[c*8 +: 8] = fq[c].pop_front();
    upd_empty();
  endtask

  task automatic load(input int n);
    for (int c = 0; c < 9; c++) begin
      fq[c].delete();
      repeat (n) fq[c].push_back(8'($urandom));
    end
    upd_empty();
  endtask

  // Row-major expectations from the FIFO contents, then a one-cycle start pulse
  task automatic go(input int rows, input logic [9:0] base);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < 9; c++) exp_q.push_back({10'(int'(base) + r * 9 + c), fq[c][r]});
    exp_n = rows * 9;
    exp_lat = (rows == 0) ? 1 : 18 * rows + 1;
    exp_last = 10'(int'(base) + rows * 9 - 1);
    chk_last = rows != 0;
    nwr0 = nwr;
    num_rows = 8'(rows);
    base_addr = base;
    start = 1;
    tick();
    start = 0;
    start_cyc = cyc;
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    waiting = 1;
    for (int i = 0; i < 700 && done_cnt == d0; i++) tick();
    waiting = 0;
  endtask

  initial begin
    start = 1;
    num_rows = 8'd3;
    repeat (3) tick();
    reset = 0;
    start = 0;
    tick();
    load(2);
    go(2, 10'h010);
    wait_done();
    load(2);
    go(2, 10'h000);
    exp_lat = 41;
    for (int i = 0; i < 50 && !en[2]; i++) tick();
    mask[3] = 1;
    upd_empty();
    repeat (5) tick();
    mask = '0;
    upd_empty();
    wait_done();
    load(1);
    go(0, 10'h123);
    wait_done();
    load(1);
    go(1, 10'h3FC);
    exp_last = 10'h004;
    wait_done();
    load(2);
    go(2, 10'h050);
    for (int i = 0; i < 50 && nwr - nwr0 < 4; i++) tick();
    reset = 1;
    tick();
    reset = 0;
    tick();
    load(1);
    go(1, 10'h000);
    wait_done();
    load(2);
    go(2, 10'h100);
    repeat (6) tick();
    start = 1;
    num_rows = 8'd5;
    base_addr = 10'h000;
    tick();
    start = 0;
    wait_done();
    repeat (5) begin
      int rows;
      rows = int'($urandom_range(0, 3));
      load(rows + int'($urandom_range(0, 1)));
      go(rows, 10'($urandom_range(0, 1023)));
      wait_done();
    end
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
